arbitro_memoria_dados: RTL

- Two-port arbiter that shares the single-port data memory between the CPU load/store path (port A) and the debug/loader port (port B).
- Serialises requests, drives the memory strobes, address and write data.
- Registers the memory read data and returns it to the winning requester with a one-cycle Ack pulse.
- Sits between the datapath/loader and the data memory. The memory writes on posedge Clock and reads on negedge Clock.

---
 rtl/arbitro_pkg.sv | 19 +
 rtl/arbitro_memoria_dados_seletor_rr.sv | 45 ++++
 rtl/arbitro_memoria_dados.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/arbitro_pkg.sv
// arbitro_pkg
//   Shared definitions for the data-memory arbiter.
//   - estado_t : FSM state encoding (OCIOSO, ACESSO, RESPOSTA)
//   - PORTA_A / PORTA_B : bit positions of each port in the one-hot grant {B,A}
//   Optional macro used by the importing files: ARB_PRIORIDADE_FIXA_EN
package arbitro_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  // One bit wide so they can index the grant vector and be compared with
  // the one-bit last-granted register without width casts.
  localparam logic PORTA_A = 1'b0;
  localparam logic PORTA_B = 1'b1;

endpackage

// File: rtl/arbitro_memoria_dados_seletor_rr.sv
// seletor_rr
//   Combinational winner selection between port A and port B.
//   Ports:
//     ReqA, ReqB  in   requests of each port
//     Ultimo      in   last granted port (PORTA_A / PORTA_B)
//     Concessao   out  one-hot grant {B,A}; 00 when nobody requests
//   Macro ARB_PRIORIDADE_FIXA_EN: when defined, A always wins a tie and
//   Ultimo is ignored; otherwise ties go to the port that did not win last.
module seletor_rr
  import arbitro_pkg::*;
(
  input  logic       ReqA,
  input  logic       ReqB,
  input  logic       Ultimo,
  output logic [1:0] Concessao
);

`ifdef ARB_PRIORIDADE_FIXA_EN
  logic unused_ultimo;
  assign unused_ultimo = Ultimo;

  always_comb begin
    Concessao = 2'b00;
    if (ReqA)
      Concessao[PORTA_A] = 1'b1;
    else if (ReqB)
      Concessao[PORTA_B] = 1'b1;
  end
`else
  always_comb begin
    Concessao = 2'b00;
    if (ReqA && ReqB) begin
      if (Ultimo == PORTA_B)
        Concessao[PORTA_A] = 1'b1;
      else
        Concessao[PORTA_B] = 1'b1;
    end else if (ReqA) begin
      Concessao[PORTA_A] = 1'b1;
    end else if (ReqB) begin
      Concessao[PORTA_B] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados
//   Shares the single-port data memory between the CPU load/store path
//   (port A) and the debug/loader port (port B). One access at a time,
//   minimum three cycles per access; all outputs registered.
//   Ports:
//     Clock, Reset_n                         clock, async active-low reset
//     ReqX, EscX, EnderecoX, DadoX           port X request, write flag, address, data
//     AckX                                   one-cycle completion pulse
//     DadoLidoX                              last read data of port X
//     MemEscMem, MemLerMem                   memory write / read strobes
//     MemEndereco, MemDadoEscrito            memory address / write data
//     MemDadoLido                            memory read data (valid after negedge)
//     Concedido                              one-hot owner {B,A}
//   Macro ARB_PRIORIDADE_FIXA_EN: fixed priority to A instead of round-robin.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   OCIOSO   | idle; requests sampled at the next posedge
//   ACESSO   | strobe high for one cycle; memory acts on this cycle
//   RESPOSTA | winner's Ack high; returns to OCIOSO without arbitrating
module arbitro_memoria_dados
  import arbitro_pkg::*;
#(
  parameter int LARGURA_DADOS = 8,
  parameter int LARGURA_END   = 8
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     ReqA,
  input  logic                     EscA,
  input  logic [LARGURA_END-1:0]   EnderecoA,
  input  logic [LARGURA_DADOS-1:0] DadoA,
  output logic                     AckA,
  output logic [LARGURA_DADOS-1:0] DadoLidoA,
  input  logic                     ReqB,
  input  logic                     EscB,
  input  logic [LARGURA_END-1:0]   EnderecoB,
  input  logic [LARGURA_DADOS-1:0] DadoB,
  output logic                     AckB,
  output logic [LARGURA_DADOS-1:0] DadoLidoB,
  output logic                     MemEscMem,
  output logic                     MemLerMem,
  output logic [LARGURA_END-1:0]   MemEndereco,
  output logic [LARGURA_DADOS-1:0] MemDadoEscrito,
  input  logic [LARGURA_DADOS-1:0] MemDadoLido,
  output logic [1:0]               Concedido
);

  estado_t                  estado, estado_prox;
  logic                     esc_prox, ler_prox;
  logic [LARGURA_END-1:0]   end_prox;
  logic [LARGURA_DADOS-1:0] dado_prox;
  logic                     ack_a_prox, ack_b_prox;
  logic [LARGURA_DADOS-1:0] lido_a_prox, lido_b_prox;
  logic [1:0]               conc_prox;
  logic [1:0]               concessao;
  logic                     ultimo_sel;

`ifdef ARB_PRIORIDADE_FIXA_EN
  assign ultimo_sel = PORTA_B;
`else
  logic ultimo, ultimo_prox;
  assign ultimo_sel = ultimo;
`endif

  seletor_rr u_seletor (
    .ReqA      (ReqA),
    .ReqB      (ReqB),
    .Ultimo    (ultimo_sel),
    .Concessao (concessao)
  );

  always_comb begin
    estado_prox = estado;
    esc_prox    = 1'b0;
    ler_prox    = 1'b0;
    end_prox    = MemEndereco;
    dado_prox   = MemDadoEscrito;
    ack_a_prox  = 1'b0;
    ack_b_prox  = 1'b0;
    lido_a_prox = DadoLidoA;
    lido_b_prox = DadoLidoB;
    conc_prox   = Concedido;
`ifndef ARB_PRIORIDADE_FIXA_EN
    ultimo_prox = ultimo;
`endif
    case (estado)
      OCIOSO: begin
        if (concessao != 2'b00) begin
          conc_prox   = concessao;
          estado_prox = ACESSO;
          if (concessao[PORTA_A]) begin
            end_prox  = EnderecoA;
            dado_prox = DadoA;
            esc_prox  = EscA;
            ler_prox  = ~EscA;
          end else begin
            end_prox  = EnderecoB;
            dado_prox = DadoB;
            esc_prox  = EscB;
            ler_prox  = ~EscB;
          end
`ifndef ARB_PRIORIDADE_FIXA_EN
          ultimo_prox = concessao[PORTA_B] ? PORTA_B : PORTA_A;
`endif
        end
      end
      ACESSO: begin
        // Strobes fall by default; read data is valid since the negedge.
        estado_prox = RESPOSTA;
        if (Concedido[PORTA_A]) begin
          ack_a_prox = 1'b1;
          if (MemLerMem)
            lido_a_prox = MemDadoLido;
        end
        if (Concedido[PORTA_B]) begin
          ack_b_prox = 1'b1;
          if (MemLerMem)
            lido_b_prox = MemDadoLido;
        end
      end
      RESPOSTA: begin
        conc_prox   = 2'b00;
        estado_prox = OCIOSO;
      end
      default: begin
        conc_prox   = 2'b00;
        estado_prox = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado         <= OCIOSO;
      MemEscMem      <= 1'b0;
      MemLerMem      <= 1'b0;
      MemEndereco    <= '0;
      MemDadoEscrito <= '0;
      AckA           <= 1'b0;
      AckB           <= 1'b0;
      DadoLidoA      <= '0;
      DadoLidoB      <= '0;
      Concedido      <= 2'b00;
    end else begin
      estado         <= estado_prox;
      MemEscMem      <= esc_prox;
      MemLerMem      <= ler_prox;
      MemEndereco    <= end_prox;
      MemDadoEscrito <= dado_prox;
      AckA           <= ack_a_prox;
      AckB           <= ack_b_prox;
      DadoLidoA      <= lido_a_prox;
      DadoLidoB      <= lido_b_prox;
      Concedido      <= conc_prox;
    end
  end

`ifndef ARB_PRIORIDADE_FIXA_EN
  // Reset value B makes A the winner of the first tie.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      ultimo <= PORTA_B;
    else
      ultimo <= ultimo_prox;
  end
`endif

endmodule
